// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO in front of a simple-dual-port BRAM.
// A 2-entry output buffer hides the BRAM's 1-cycle read latency.
module bram_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH)+1:0]   count,
  output logic                       wen,
  output logic [$clog2(DEPTH)-1:0]   waddr,
  output logic [WIDTH-1:0]           wline,
  output logic                       ren,
  output logic [$clog2(DEPTH)-1:0]   raddr,
  input  logic [WIDTH-1:0]           rline
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    ram_cnt;
  logic           inflight;
  logic [WIDTH-1:0] ob [2];
  logic           head;
  logic [1:0]     ob_cnt;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ;
  logic       wslot;

  assign in_ready  = (ram_cnt != FULL);
  assign out_valid = (ob_cnt != 2'd0);
  assign out_data  = ob[head];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Buffer slots already claimed after this cycle's pop.
  assign occ = {1'b0, ob_cnt}
             + {2'b0, inflight}
             - {2'b0, pop};
  assign issue = (ram_cnt != '0)
               && (occ < 3'd2);

  assign wslot = head ^ ob_cnt[0];

  assign wen   = push & ~flush & rst;
  assign waddr = wptr;
  assign wline = in_data;
  assign ren   = issue & ~flush;
  assign raddr = rptr;

  assign count = CW'(ram_cnt)
               + CW'(inflight)
               + CW'(ob_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      head     <= 1'b0;
      ob_cnt   <= '0;
      ob[0]    <= '0;
      ob[1]    <= '0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      head     <= 1'b0;
      ob_cnt   <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (issue)
        rptr <= rptr + 1'b1;
      ram_cnt <= ram_cnt
               + (AW+1)'(push)
               - (AW+1)'(issue);
      inflight <= issue;
      if (inflight)
        ob[wslot] <= rline;
      if (pop)
        head <= ~head;
      ob_cnt <= ob_cnt
              + 2'(inflight)
              - 2'(pop);
    end
  end

endmodule

// File: tb/tb_bram_fifo.sv
// Bench for bram_fifo: BRAM model, queue-based reference model,
// per-cycle compare process and directed/random stimulus.
module tb_bram_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [AW+1:0] count;
  logic wen;
  logic [AW-1:0] waddr;
  logic [W-1:0] wline;
  logic ren;
  logic [AW-1:0] raddr;
  logic [W-1:0] rline;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count),
    .wen(wen), .waddr(waddr), .wline(wline),
    .ren(ren), .raddr(raddr), .rline(rline)
  );

  // BRAM: 1-cycle read, write-to-read forwarding
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (wen)
      mem[waddr] <= wline;
    if (ren)
      rline <= (wen && waddr == raddr)
             ? wline : mem[raddr];
  end

  // Reference: ordered contents, each with its push edge
  typedef struct {
    logic [W-1:0] d;
    int t;
  } ent_t;
  ent_t q[$];
  int ecnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else begin
      ecnt <= ecnt + 1;
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0)
          void'(q.pop_front());
        if (in_valid && in_ready)
          q.push_back('{in_data, ecnt + 1});
      end
    end
  end

  task automatic chk(string nm, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  // Oldest word visible two edges after its push
  always @(negedge clk) begin
    if (rst) begin
      logic ev;
      ev = 1'b0;
      if (q.size() > 0)
        ev = (ecnt - q[0].t) >= 2;
      chk("m_count", count, q.size());
      chk("m_out_valid", out_valid, ev);
      if (out_valid && q.size() > 0)
        chk("m_out_data", out_data, q[0].d);
      if (q.size() < D)
        chk("m_in_ready_free", in_ready, 1);
      if (q.size() >= D + 2)
        chk("m_in_ready_full", in_ready, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int nxt;
    int cyc;
    int steady;
    logic last_ir;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;

    // reset with random inputs
    repeat (6) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_wen", wen, 0);
      chk("rst_ren", ren, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;

    // first word latency
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hA5A5A5A5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_e0_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_e1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_e2_valid", out_valid, 1);
    chk("lat_e2_data", out_data, 32'hA5A5A5A5);
    chk("lat_e2_count", count, 1);
    chk("lat_model_sz", q.size(), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("lat_pop_count", count, 0);

    // fill without pops
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = i;
      if (in_ready)
        acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_accepted", acc, D + 2);
    chk("fill_count", count, D + 2);
    chk("fill_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < D + 2; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, k);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_count", count, 0);

    // streaming push and pop every cycle
    steady = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'h1000 + n;
      chk("stream_in_ready", in_ready, 1);
      if (n == 2)
        chk("stream_lat", out_valid, 0);
      if (n >= 3)
        chk("stream_bubble", out_valid, 1);
      if (n == 3)
        steady = int'(count);
      if (n > 3)
        chk("stream_count", count, steady);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (count != 0)
        @(negedge clk);
    end
    chk("stream_empty", count, 0);
    out_ready = 1'b0;

    // random traffic with wrap and backpressure
    nxt = 0;
    cyc = 0;
    last_ir = 1'b0;
    while (nxt < 3000 && cyc < 20000) begin
      @(negedge clk);
      if (in_valid && last_ir)
        nxt++;
      in_valid  = ($urandom_range(9) < 7)
                && (nxt < 3000);
      in_data   = nxt;
      out_ready = $urandom_range(9) < 6;
      last_ir   = in_ready;
      cyc++;
    end
    chk("wrap_pushed", nxt, 3000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (count != 0)
        @(negedge clk);
    end
    chk("wrap_drain", count, 0);
    out_ready = 1'b0;

    // flush together with push and pop
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'h100 + i;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("fl_pre_count", count, 5);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    in_data = 32'h77;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fl_e0_valid", out_valid, 0);
    @(negedge clk);
    chk("fl_e1_valid", out_valid, 0);
    @(negedge clk);
    chk("fl_e2_valid", out_valid, 1);
    chk("fl_e2_data", out_data, 32'h77);
    chk("fl_e2_count", count, 1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("fl_only_one", out_valid, 0);
    end
    out_ready = 1'b0;

    // async reset with a read in flight
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'h11;
    @(negedge clk);
    in_data = 32'h22;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_pre_valid", out_valid, 1);
    chk("mr_pre_data", out_data, 32'h11);
    rst = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_count", count, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_ren", ren, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr_e0_valid", out_valid, 0);
    @(negedge clk);
    chk("mr_e1_valid", out_valid, 0);
    @(negedge clk);
    chk("mr_e2_valid", out_valid, 1);
    chk("mr_e2_data", out_data, 32'h1);
    chk("mr_e2_count", count, 1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mr_no_stale", out_valid, 0);
    end
    out_ready = 1'b0;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
